// File: rtl/decode_format_mux.sv
// rtl/decode_format_mux.sv - priority mux of parallel format-decoder records onto one registered decode bus with skid buffer
// Optional: DECODE_MUX_MULTIHIT_CHECK_EN adds multiHit_o / multiHitCount_o.
module decode_format_mux #(
  parameter int NUM_CH = 6,
  parameter int ADDR_W = 64,
  parameter int OPC_W  = 6,
  parameter int XOPC_W = 10,
  parameter int REG_W  = 5,
  parameter int IMM_W  = 16,
  parameter int FUC_W  = 3,
  parameter int FMT_W  = 5,
  parameter int REC_W  = FMT_W + 3*REG_W + 3 + IMM_W + 1 + 6 + XOPC_W + 1 + 2 + 2 + 1 + FUC_W
) (
  input  logic                    clock_i,
  input  logic                    reset_i,
  input  logic                    in_valid_i,
  output logic                    in_ready_o,
  input  logic [ADDR_W-1:0]       instructionAddress_i,
  input  logic [OPC_W-1:0]        opcode_i,
  input  logic [NUM_CH-1:0]       chEnable_i,
  input  logic [NUM_CH*REC_W-1:0] chRec_i,
  output logic                    out_valid_o,
  input  logic                    out_ready_i,
  output logic [ADDR_W-1:0]       instructionAddress_o,
  output logic [OPC_W-1:0]        opcode_o,
  output logic [FMT_W-1:0]        format_o,
  output logic [REG_W-1:0]        reg1_o,
  output logic [REG_W-1:0]        reg2_o,
  output logic [REG_W-1:0]        reg3_o,
  output logic [2:0]              regEn_o,
  output logic [63:0]             imm_o,
  output logic                    immEnable_o,
  output logic [XOPC_W-1:0]       xOpcode_o,
  output logic                    xOpcodeEnable_o,
  output logic [1:0]              bit_o,
  output logic [1:0]              bitEn_o,
  output logic                    reg2ValOrZero_o,
`ifdef DECODE_MUX_MULTIHIT_CHECK_EN
  output logic                    multiHit_o,
  output logic [15:0]             multiHitCount_o,
`endif
  output logic [FUC_W-1:0]        functionalUnitCode_o
);

  typedef struct packed {
    logic [FMT_W-1:0]  fmt;
    logic [REG_W-1:0]  reg1;
    logic [REG_W-1:0]  reg2;
    logic [REG_W-1:0]  reg3;
    logic [2:0]        regEn;
    logic [IMM_W-1:0]  imm;
    logic              immSigned;
    logic [5:0]        immShift;
    logic [XOPC_W-1:0] xopc;
    logic              xopcEn;
    logic [1:0]        bitv;
    logic [1:0]        bitEn;
    logic              reg2ValOrZero;
    logic [FUC_W-1:0]  fuc;
  } rec_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [OPC_W-1:0]  opc;
    logic [FMT_W-1:0]  fmt;
    logic [REG_W-1:0]  reg1;
    logic [REG_W-1:0]  reg2;
    logic [REG_W-1:0]  reg3;
    logic [2:0]        regEn;
    logic [63:0]       imm;
    logic              immEn;
    logic [XOPC_W-1:0] xopc;
    logic              xopcEn;
    logic [1:0]        bitv;
    logic [1:0]        bitEn;
    logic              reg2ValOrZero;
    logic [FUC_W-1:0]  fuc;
  } dec_t;

  rec_t        sel;
  dec_t        dec;
  dec_t        out_q;
  dec_t        skid_q;
  logic        out_valid_q;
  logic        skid_valid_q;
  logic [63:0] imm_ext;
  logic        transfer;

  // Descending scan so the lowest-index hit is the last (winning) assignment;
  // no hit leaves an all-zero record, i.e. INVALID format with every enable clear.
  always_comb begin
    sel = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (chEnable_i[i]) sel = rec_t'(chRec_i[(NUM_CH-1-i)*REC_W +: REC_W]);
    end
  end

  always_comb begin
    imm_ext = sel.immSigned ? {{(64-IMM_W){sel.imm[IMM_W-1]}}, sel.imm}
                            : {{(64-IMM_W){1'b0}}, sel.imm};
    dec               = '0;
    dec.addr          = instructionAddress_i;
    dec.opc           = opcode_i;
    dec.fmt           = sel.fmt;
    dec.reg1          = sel.reg1;
    dec.reg2          = sel.reg2;
    dec.reg3          = sel.reg3;
    dec.regEn         = sel.regEn;
    dec.imm           = imm_ext << sel.immShift;
    dec.immEn         = (sel.fmt != '0);
    dec.xopc          = sel.xopc;
    dec.xopcEn        = sel.xopcEn;
    dec.bitv          = sel.bitv;
    dec.bitEn         = sel.bitEn;
    dec.reg2ValOrZero = sel.reg2ValOrZero;
    dec.fuc           = sel.fuc;
  end

  assign in_ready_o = !skid_valid_q;
  assign transfer   = in_valid_i && in_ready_o;

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      out_valid_q  <= 1'b0;
      out_q        <= '0;
      skid_valid_q <= 1'b0;
      skid_q       <= '0;
    end else if (skid_valid_q) begin
      // Input is blocked while the skid holds a word; drain it on the next out fire.
      if (out_ready_i) begin
        out_q        <= skid_q;
        skid_valid_q <= 1'b0;
      end
    end else if (transfer) begin
      if (!out_valid_q || out_ready_i) begin
        out_q       <= dec;
        out_valid_q <= 1'b1;
      end else begin
        skid_q       <= dec;
        skid_valid_q <= 1'b1;
      end
    end else if (out_ready_i) begin
      out_valid_q <= 1'b0;
    end
  end

`ifdef DECODE_MUX_MULTIHIT_CHECK_EN
  logic        multi_hit_q;
  logic [15:0] multi_cnt_q;
  logic        multi_now;

  assign multi_now = transfer && ((chEnable_i & (chEnable_i - 1'b1)) != '0);

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      multi_hit_q <= 1'b0;
      multi_cnt_q <= '0;
    end else if (multi_now) begin
      multi_hit_q <= 1'b1;
      if (multi_cnt_q != 16'hFFFF) multi_cnt_q <= multi_cnt_q + 16'd1;
    end
  end

  assign multiHit_o      = multi_hit_q;
  assign multiHitCount_o = multi_cnt_q;
`endif

  assign out_valid_o          = out_valid_q;
  assign instructionAddress_o = out_q.addr;
  assign opcode_o             = out_q.opc;
  assign format_o             = out_q.fmt;
  assign reg1_o               = out_q.reg1;
  assign reg2_o               = out_q.reg2;
  assign reg3_o               = out_q.reg3;
  assign regEn_o              = out_q.regEn;
  assign imm_o                = out_q.imm;
  assign immEnable_o          = out_q.immEn;
  assign xOpcode_o            = out_q.xopc;
  assign xOpcodeEnable_o      = out_q.xopcEn;
  assign bit_o                = out_q.bitv;
  assign bitEn_o              = out_q.bitEn;
  assign reg2ValOrZero_o      = out_q.reg2ValOrZero;
  assign functionalUnitCode_o = out_q.fuc;

endmodule
